uart_rx_frontend: RTL and testbench

UART_RX_FRONTEND -- requirements
Module: uart_rx_frontend

---
 rtl/uart_rx_frontend.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: 2-flop line synchronizer, mid-bit sampling FSM and a
// first-word-fall-through receive FIFO with frame-error and overrun pulses.
//
// state     | meaning
// ----------|--------------------------------------------------------------
// IDLE      | line idle, waiting for a low level on the synchronized rxd
// START     | half-bit wait, then confirm the start bit is still low
// DATA      | sample 8 data bits LSB first, one per bit period
// STOP      | sample the stop bit; high pushes the byte, low is a frame error
// WAIT_IDLE | after a frame error, hold off until the line returns high
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rxd,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          rx_busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int          PW         = $clog2(FIFO_DEPTH);
    localparam logic [15:0] HALF_LOAD  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LOAD  = 16'(CLKS_PER_BIT - 1);
    localparam logic [PW:0] LEVEL_FULL = (PW + 1)'(FIFO_DEPTH);
    localparam logic [PW:0] LEVEL_ONE  = (PW + 1)'(1);
    localparam logic [PW:0] LEVEL_ZERO = '0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;

    logic          rxd_meta;
    logic          rxd_sync;
    state_t        state;
    logic [15:0]   timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   level;

    logic          timer_done;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          do_write;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
        end
    end

    assign timer_done = (timer == 16'd0);
    assign push       = (state == S_STOP) && timer_done && rxd_sync;
    assign pop        = rx_valid && rx_ready;
    assign fifo_full  = (level == LEVEL_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign do_write   = push && (!fifo_full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= push && fifo_full && !pop;
            case (state)
                S_IDLE: begin
                    if (!rxd_sync) begin
                        state   <= S_START;
                        timer   <= HALF_LOAD;
                        rx_busy <= 1'b1;
                    end
                end
                S_START: begin
                    if (!timer_done) begin
                        timer <= timer - 16'd1;
                    end else if (!rxd_sync) begin
                        state   <= S_DATA;
                        timer   <= FULL_LOAD;
                        bit_idx <= 3'd0;
                    end else begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (!timer_done) begin
                        timer <= timer - 16'd1;
                    end else begin
                        shift_reg <= {rxd_sync, shift_reg[7:1]};
                        timer     <= FULL_LOAD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (!timer_done) begin
                        timer <= timer - 16'd1;
                    end else if (rxd_sync) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        state     <= S_WAIT_IDLE;
                        frame_err <= 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rxd_sync) begin
                        state   <= S_IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= shift_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign rx_valid   = (level != LEVEL_ZERO);
    assign rx_data    = rx_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_level = level;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend: directed scenarios plus a random
// byte stream compared against a queue-based reference of good frames.
module tb_uart_rx_frontend;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] fifo_level;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    uart_rx_frontend #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .fifo_level (fifo_level),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Monitor: everything the consumer sees, sampled on the falling edge.
    int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, long_cnt = 0, valid_cnt = 0, got_n = 0;
    logic [7:0] got_mem [0:255];
    logic       fe_prev = 1'b0, ov_prev = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            fe_prev = 1'b0;
            ov_prev = 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                got_mem[got_n] = rx_data;
                got_n++;
            end
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
            if ((frame_err && fe_prev) || (overrun && ov_prev)) long_cnt++;
            if (rx_valid) valid_cnt++;
            fe_prev = frame_err;
            ov_prev = overrun;
        end
    end

    logic rand_ready = 1'b0;
    int   last_fall = -1;
    logic valid_at_fall = 1'b0;
    int   push_lat = 155;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // Drives one frame starting right after an edge; optionally pulses rx_ready
    // for the single cycle that ends on frame-relative edge pop_at.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int pop_at);
        logic seen;
        int   seg;
        seen = 1'b0;
        last_fall = -1;
        rxd = 1'b0;
        for (int c = 1; c <= FRAME; c++) begin
            tick();
            seg = c / CPB;
            if (seg == 0) rxd = 1'b0;
            else if (seg <= 8) rxd = d[seg-1];
            else rxd = stop;
            if (pop_at > 0) rx_ready = (c == pop_at - 1);
            if (rx_busy) seen = 1'b1;
            else if (seen && last_fall < 0) begin
                last_fall = c;
                valid_at_fall = rx_valid;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({rx_valid, rx_data, fifo_level, rx_busy, frame_err, overrun} !== 15'd0) begin
                err_cnt++;
                $display("FAIL reset_outputs: got valid=%b data=%h level=%0d busy=%b fe=%b ov=%b, expected all 0",
                         rx_valid, rx_data, fifo_level, rx_busy, frame_err, overrun);
            end
            rxd = ~rxd;
        end
        rxd = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);
        cmp_cnt++;
        if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_release: got busy=%b valid=%b, expected 0 0", rx_busy, rx_valid);
        end
    endtask

    task automatic test_single();
        int g0, f0, o0, v0;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; v0 = valid_cnt;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 0);
        idle(20);
        cmp_cnt++;
        if (got_n - g0 !== 1 || got_mem[g0] !== 8'hA5) begin
            err_cnt++;
            $display("FAIL single_byte: got count=%0d byte=%h, expected 1 a5", got_n - g0, got_mem[g0]);
        end
        cmp_cnt++;
        if (valid_cnt - v0 !== 1) begin
            err_cnt++;
            $display("FAIL single_valid_width: got %0d cycles, expected 1", valid_cnt - v0);
        end
        cmp_cnt++;
        if (fifo_level !== 3'd0 || fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            err_cnt++;
            $display("FAIL single_clean: got level=%0d fe=%0d ov=%0d, expected 0 0 0",
                     fifo_level, fe_cnt - f0, ov_cnt - o0);
        end
        cmp_cnt++;
        if (last_fall < 153 || last_fall > 156) begin
            err_cnt++;
            $display("FAIL stop_sample_time: got edge %0d, expected 153..156", last_fall);
        end else begin
            push_lat = last_fall;
        end
        cmp_cnt++;
        if (valid_at_fall !== 1'b1) begin
            err_cnt++;
            $display("FAIL push_latency: got valid=%b one cycle after stop sample, expected 1", valid_at_fall);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_glitch();
        int g0, f0, o0, v0;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; v0 = valid_cnt;
        rx_ready = 1'b1;
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(30);
        cmp_cnt++;
        if (rx_busy !== 1'b0 || valid_cnt - v0 !== 0 || got_n - g0 !== 0) begin
            err_cnt++;
            $display("FAIL glitch_reject: got busy=%b valid_cycles=%0d pops=%0d, expected 0 0 0",
                     rx_busy, valid_cnt - v0, got_n - g0);
        end
        cmp_cnt++;
        if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            err_cnt++;
            $display("FAIL glitch_pulses: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun();
        int g0, f0, o0, l0;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; l0 = long_cnt;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 0);
            idle(3);
        end
        idle(10);
        cmp_cnt++;
        if (fifo_level !== 3'd4) begin
            err_cnt++;
            $display("FAIL overrun_level: got %0d, expected 4", fifo_level);
        end
        cmp_cnt++;
        if (ov_cnt - o0 !== 1 || fe_cnt - f0 !== 0 || long_cnt - l0 !== 0) begin
            err_cnt++;
            $display("FAIL overrun_pulse: got ov=%0d fe=%0d long=%0d, expected 1 0 0",
                     ov_cnt - o0, fe_cnt - f0, long_cnt - l0);
        end
        rx_ready = 1'b1;
        idle(10);
        rx_ready = 1'b0;
        cmp_cnt++;
        if (got_n - g0 !== 4 || fifo_level !== 3'd0) begin
            err_cnt++;
            $display("FAIL overrun_drain: got pops=%0d level=%0d, expected 4 0", got_n - g0, fifo_level);
        end
        for (int i = 0; i < 4; i++) begin
            cmp_cnt++;
            if (got_mem[g0+i] !== 8'(i + 1)) begin
                err_cnt++;
                $display("FAIL overrun_order[%0d]: got %h, expected %h", i, got_mem[g0+i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] b [5];
        int g0, o0;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        g0 = got_n; o0 = ov_cnt;
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_frame(b[i], 1'b1, 0);
            idle(3);
        end
        cmp_cnt++;
        if (fifo_level !== 3'd4) begin
            err_cnt++;
            $display("FAIL full_pop_prefill: got %0d, expected 4", fifo_level);
        end
        send_frame(b[4], 1'b1, push_lat);
        idle(10);
        cmp_cnt++;
        if (ov_cnt - o0 !== 0 || fifo_level !== 3'd4 || got_n - g0 !== 1) begin
            err_cnt++;
            $display("FAIL full_pop_same_cycle: got ov=%0d level=%0d pops=%0d, expected 0 4 1",
                     ov_cnt - o0, fifo_level, got_n - g0);
        end
        rx_ready = 1'b1;
        idle(10);
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cmp_cnt++;
            if (got_mem[g0+i] !== b[i]) begin
                err_cnt++;
                $display("FAIL full_pop_order[%0d]: got %h, expected %h", i, got_mem[g0+i], b[i]);
            end
        end
    endtask

    task automatic test_frame_err();
        int g0, f0, o0, l0;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; l0 = long_cnt;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0, 0);
        idle(40 * CPB);
        cmp_cnt++;
        if (rx_busy !== 1'b1) begin
            err_cnt++;
            $display("FAIL break_busy: got %b while line held low, expected 1", rx_busy);
        end
        cmp_cnt++;
        if (fe_cnt - f0 !== 1 || long_cnt - l0 !== 0 || ov_cnt - o0 !== 0) begin
            err_cnt++;
            $display("FAIL break_frame_err: got fe=%0d long=%0d ov=%0d, expected 1 0 0",
                     fe_cnt - f0, long_cnt - l0, ov_cnt - o0);
        end
        cmp_cnt++;
        if (got_n - g0 !== 0 || fifo_level !== 3'd0) begin
            err_cnt++;
            $display("FAIL break_no_push: got pops=%0d level=%0d, expected 0 0", got_n - g0, fifo_level);
        end
        rxd = 1'b1;
        idle(10);
        cmp_cnt++;
        if (rx_busy !== 1'b0 || fe_cnt - f0 !== 1) begin
            err_cnt++;
            $display("FAIL break_release: got busy=%b fe=%0d, expected 0 1", rx_busy, fe_cnt - f0);
        end
        rx_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] exp_q [$];
        logic [7:0] d;
        logic       bad;
        int g0, f0, o0, b0, l0, nbad;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt; b0 = both_cnt; l0 = long_cnt; nbad = 0;
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            send_frame(d, !bad, 0);
            if (bad) begin
                rxd = 1'b1;
                nbad++;
            end else begin
                exp_q.push_back(d);
            end
            idle($urandom_range(3, 20));
        end
        rand_ready = 1'b0;
        rx_ready = 1'b1;
        idle(20);
        rx_ready = 1'b0;
        cmp_cnt++;
        if (fe_cnt - f0 !== nbad || ov_cnt - o0 !== 0) begin
            err_cnt++;
            $display("FAIL random_pulses: got fe=%0d ov=%0d, expected %0d 0", fe_cnt - f0, ov_cnt - o0, nbad);
        end
        cmp_cnt++;
        if (both_cnt - b0 !== 0 || long_cnt - l0 !== 0) begin
            err_cnt++;
            $display("FAIL random_pulse_shape: got both=%0d long=%0d, expected 0 0", both_cnt - b0, long_cnt - l0);
        end
        cmp_cnt++;
        if (got_n - g0 !== exp_q.size()) begin
            err_cnt++;
            $display("FAIL random_count: got %0d bytes, expected %0d", got_n - g0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            cmp_cnt++;
            if (got_mem[g0+i] !== exp_q[i]) begin
                err_cnt++;
                $display("FAIL random_byte[%0d]: got %h, expected %h", i, got_mem[g0+i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int g0, f0, o0;
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b1, 0);
        idle(5);
        rxd = 1'b0;
        idle(CPB);
        rxd = 1'b1;
        idle(4 * CPB + CPB / 2);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp_cnt++;
            if ({rx_valid, rx_data, fifo_level, rx_busy, frame_err, overrun} !== 15'd0) begin
                err_cnt++;
                $display("FAIL midframe_reset_outputs: got valid=%b data=%h level=%0d busy=%b fe=%b ov=%b, expected all 0",
                         rx_valid, rx_data, fifo_level, rx_busy, frame_err, overrun);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        g0 = got_n; f0 = fe_cnt; o0 = ov_cnt;
        idle(20);
        rx_ready = 1'b1;
        send_frame(8'h5A, 1'b1, 0);
        idle(20);
        rx_ready = 1'b0;
        cmp_cnt++;
        if (got_n - g0 !== 1 || got_mem[g0] !== 8'h5A) begin
            err_cnt++;
            $display("FAIL midframe_reset_recv: got count=%0d first=%h, expected 1 5a", got_n - g0, got_mem[g0]);
        end
        cmp_cnt++;
        if (fifo_level !== 3'd0 || fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin
            err_cnt++;
            $display("FAIL midframe_reset_clean: got level=%0d fe=%0d ov=%0d, expected 0 0 0",
                     fifo_level, fe_cnt - f0, ov_cnt - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_overrun();
        test_full_pop();
        test_frame_err();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
